dma_request_queue: RTL and testbench

- Sits directly downstream of control_unit. Accepts RAM-instruction address pairs (cache_addr, main_mem_addr plus direction) and buffers them in a FIFO.
- Expands each request into a burst of BURST_LEN single-word transfers toward the main-memory/cache interface, using a req/ack handshake per beat.
- Reports idle so control_unit can stall on a memory fence.

---
 rtl/dma_request_queue.sv | 127 ++++++++++++
 tb/tb_dma_request_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_request_queue.sv
// dma_request_queue: buffers control_unit RAM-instruction address pairs in a
// small FIFO and expands each one into a burst of single-word memory beats,
// using a req/ack handshake per beat and a single-cycle completion pulse.
module dma_request_queue #(
  parameter int LOG_DEPTH = 2,
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_write,
  input  logic [ADDR_W-1:0]   in_cache_addr,
  input  logic [ADDR_W-1:0]   in_main_mem_addr,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_write,
  output logic [ADDR_W-1:0]   mem_req_cache_addr,
  output logic [ADDR_W-1:0]   mem_req_main_addr,
  input  logic                mem_resp_valid,
  output logic [LOG_DEPTH:0]  count,
  output logic                idle
);

  localparam int DEPTH   = 1 << LOG_DEPTH;
  localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int ENTRY_W = 1 + 2 * ADDR_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ENTRY_W-1:0] r_fifo [DEPTH];
  logic [LOG_DEPTH:0] r_wr_ptr;
  logic [LOG_DEPTH:0] r_rd_ptr;

  logic               r_write;
  logic [ADDR_W-1:0]  r_cache_base;
  logic [ADDR_W-1:0]  r_main_base;
  logic [BEAT_W-1:0]  r_beat;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_last_beat;
  logic [ENTRY_W-1:0] w_head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[LOG_DEPTH-1:0] == r_rd_ptr[LOG_DEPTH-1:0]) &&
                       (r_wr_ptr[LOG_DEPTH] != r_rd_ptr[LOG_DEPTH]);
  assign w_push      = in_valid && !w_full;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_head      = r_fifo[r_rd_ptr[LOG_DEPTH-1:0]];

  // FIFO storage: entries need no reset, only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[LOG_DEPTH-1:0]] <= {in_write, in_cache_addr, in_main_mem_addr};
    end
  end

  // FIFO pointer update; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Engine state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Engine next-state: pop from IDLE, handshake in ISSUE, await completion in WAIT.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty)       w_state_next = S_ISSUE;
      S_ISSUE: if (mem_req_ready)  w_state_next = S_WAIT;
      S_WAIT:  if (mem_resp_valid) w_state_next = w_last_beat ? S_IDLE : S_ISSUE;
      default:                     w_state_next = S_IDLE;
    endcase
  end

  // Burst registers: load the FIFO head on pop, advance the beat on each completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write      <= 1'b0;
      r_cache_base <= '0;
      r_main_base  <= '0;
      r_beat       <= '0;
    end else if (w_pop) begin
      r_write      <= w_head[ENTRY_W-1];
      r_cache_base <= w_head[2*ADDR_W-1:ADDR_W];
      r_main_base  <= w_head[ADDR_W-1:0];
      r_beat       <= '0;
    end else if ((r_state == S_WAIT) && mem_resp_valid && !w_last_beat) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  // Beat addresses wrap naturally at the address width.
  assign mem_req_valid      = (r_state == S_ISSUE);
  assign mem_req_write      = r_write;
  assign mem_req_cache_addr = r_cache_base + ADDR_W'(r_beat);
  assign mem_req_main_addr  = r_main_base + ADDR_W'(r_beat);

  assign in_ready = !w_full;
  assign count    = r_wr_ptr - r_rd_ptr;
  assign idle     = w_empty && (r_state == S_IDLE);

endmodule

// File: tb/tb_dma_request_queue.sv
// Directed bench for dma_request_queue with a beat scoreboard.
module tb_dma_request_queue;

  localparam int LOG_DEPTH = 2;
  localparam int BURST_LEN = 4;
  localparam int ADDR_W    = 18;

  typedef logic [2*ADDR_W:0] beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_write;
  logic [ADDR_W-1:0] in_cache_addr;
  logic [ADDR_W-1:0] in_main_mem_addr;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_cache_addr;
  logic [ADDR_W-1:0] mem_req_main_addr;
  logic              mem_resp_valid;
  logic [LOG_DEPTH:0] count;
  logic              idle;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  logic  auto_mem;

  // Snapshot of DUT outputs taken at the falling edge of the latest cycle.
  logic              s_in_ready, s_valid, s_write, s_idle, s_hs, s_acc;
  logic [ADDR_W-1:0] s_cache, s_main;
  logic [LOG_DEPTH:0] s_count;

  always #5 clk = ~clk;

  dma_request_queue #(
    .LOG_DEPTH(LOG_DEPTH),
    .BURST_LEN(BURST_LEN),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_write          (in_write),
    .in_cache_addr     (in_cache_addr),
    .in_main_mem_addr  (in_main_mem_addr),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_write     (mem_req_write),
    .mem_req_cache_addr(mem_req_cache_addr),
    .mem_req_main_addr (mem_req_main_addr),
    .mem_resp_valid    (mem_resp_valid),
    .count             (count),
    .idle              (idle)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at negedge, score beats, record accepted pushes,
  // then after the rising edge update inputs (auto memory answers 1 cycle later).
  task automatic cycle();
    beat_t exp;
    logic [ADDR_W-1:0] c, m;
    @(negedge clk);
    s_in_ready = in_ready;
    s_valid    = mem_req_valid;
    s_write    = mem_req_write;
    s_cache    = mem_req_cache_addr;
    s_main     = mem_req_main_addr;
    s_count    = count;
    s_idle     = idle;
    s_hs       = mem_req_valid && mem_req_ready;
    s_acc      = in_valid && in_ready;
    if (s_hs) begin
      if (sb.size() != 0) exp = sb.pop_front();
      else                exp = 'x;
      check("beat", 64'({s_write, s_cache, s_main}), 64'(exp));
    end
    if (s_acc) begin
      for (int unsigned i = 0; i < BURST_LEN; i++) begin
        c = in_cache_addr + ADDR_W'(i);
        m = in_main_mem_addr + ADDR_W'(i);
        sb.push_back({in_write, c, m});
      end
    end
    @(posedge clk);
    #1;
    if (s_acc) in_valid = 1'b0;
    if (auto_mem) begin
      mem_req_ready  = 1'b1;
      mem_resp_valid = s_hs;
    end
  endtask

  task automatic push(input logic w, input logic [ADDR_W-1:0] c, input logic [ADDR_W-1:0] m);
    in_write         = w;
    in_cache_addr    = c;
    in_main_mem_addr = m;
    in_valid         = 1'b1;
    for (int unsigned n = 0; n < 300 && in_valid; n++) cycle();
    check("push_accepted", 64'(in_valid), 64'(0));
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic done;
    done = 1'b0;
    for (int unsigned n = 0; n < 800 && !done; n++) begin
      cycle();
      done = (sb.size() == 0) && s_idle;
    end
    check(tag, 64'(done), 64'(1));
  endtask

  task automatic wait_hs(input string tag);
    logic got;
    got = 1'b0;
    for (int unsigned n = 0; n < 50 && !got; n++) begin
      cycle();
      got = s_hs;
    end
    check(tag, 64'(got), 64'(1));
  endtask

  // Manually complete one beat: wait for the handshake, then pulse completion.
  task automatic manual_beat();
    wait_hs("manual_hs");
    mem_resp_valid = 1'b1;
    cycle();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_write = 1'b0;
    in_cache_addr = '0; in_main_mem_addr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; auto_mem = 1'b1;
    s_hs = 1'b0; s_acc = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    check("rst_in_ready", 64'(s_in_ready), 64'(1));
    check("rst_valid",    64'(s_valid),    64'(0));
    check("rst_write",    64'(s_write),    64'(0));
    check("rst_cache",    64'(s_cache),    64'(0));
    check("rst_main",     64'(s_main),     64'(0));
    check("rst_count",    64'(s_count),    64'(0));
    check("rst_idle",     64'(s_idle),     64'(1));
    reset = 1'b0;
    cycle();

    // 1: simple read burst, latency and idle behaviour
    push(1'b0, 18'd2, 18'd4);
    cycle();
    check("lat_idle_low",   64'(s_idle),  64'(0));
    check("lat_count1",     64'(s_count), 64'(1));
    check("lat_valid_low",  64'(s_valid), 64'(0));
    cycle();
    check("lat_valid_high", 64'(s_valid), 64'(1));
    check("lat_count0",     64'(s_count), 64'(0));
    drain("drain_t1");
    check("t1_idle", 64'(s_idle), 64'(1));

    // 2: fill queue behind a stalled burst
    auto_mem = 1'b0; mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    for (int unsigned i = 0; i < 5; i++) push(1'b0, ADDR_W'(18'h100 + 16 * i), ADDR_W'(18'h800 + 16 * i));
    cycle();
    check("full_in_ready", 64'(s_in_ready), 64'(0));
    check("full_count",    64'(s_count),    64'(4));
    in_write = 1'b1; in_cache_addr = 18'h1AA; in_main_mem_addr = 18'h2BB; in_valid = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      cycle();
      check("held_off", 64'({s_in_ready, s_count}), 64'({1'b0, 3'd4}));
    end
    mem_resp_valid = 1'b1;
    cycle();
    mem_resp_valid = 1'b0;
    auto_mem = 1'b1;
    push(1'b1, 18'h1AA, 18'h2BB);
    drain("drain_t2");

    // 3: address wrap on a write burst
    push(1'b1, 18'h3FFFE, 18'h3FFFF);
    drain("drain_t3");

    // 4: stalled request stays stable; completion pulse in ISSUE is ignored
    auto_mem = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    push(1'b0, 18'h100, 18'h200);
    cycle();
    for (int unsigned k = 0; k < 5; k++) begin
      if (k == 2) mem_resp_valid = 1'b1;
      cycle();
      mem_resp_valid = 1'b0;
      check("stall_stable", 64'({s_valid, s_cache, s_main}), 64'({1'b1, 18'h100, 18'h200}));
    end
    mem_req_ready = 1'b1;
    cycle();
    check("stall_hs", 64'(s_hs), 64'(1));
    mem_resp_valid = 1'b1;
    cycle();
    mem_resp_valid = 1'b0;
    auto_mem = 1'b1;
    drain("drain_t4");

    // 5: push on the pop edge keeps count; order kept across pointer wrap
    auto_mem = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    push(1'b0, 18'h10, 18'h20);
    push(1'b0, 18'h30, 18'h40);
    push(1'b0, 18'h50, 18'h60);
    cycle();
    check("t5_count2", 64'(s_count), 64'(2));
    mem_req_ready = 1'b1;
    for (int unsigned b = 0; b < BURST_LEN; b++) manual_beat();
    push(1'b1, 18'h70, 18'h80);
    check("pop_edge_count_before", 64'(s_count), 64'(2));
    auto_mem = 1'b1;
    cycle();
    check("pop_edge_count_after", 64'(s_count), 64'(2));
    for (int unsigned i = 0; i < 10; i++)
      push(1'(i), ADDR_W'(18'h1000 + 32 * i), ADDR_W'(18'h3F000 + 32 * i));
    drain("drain_t5");

    // 6: reset in the middle of a burst with entries queued
    auto_mem = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    push(1'b1, 18'h200, 18'h300);
    push(1'b0, 18'h210, 18'h310);
    push(1'b0, 18'h220, 18'h320);
    push(1'b0, 18'h230, 18'h330);
    cycle();
    check("t6_count3", 64'(s_count), 64'(3));
    mem_req_ready = 1'b1;
    manual_beat();
    manual_beat();
    wait_hs("beat2_hs");
    reset = 1'b1;
    sb.delete();
    auto_mem = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    check("mid_rst_idle",  64'(s_idle),  64'(1));
    check("mid_rst_count", 64'(s_count), 64'(0));
    check("mid_rst_valid", 64'(s_valid), 64'(0));
    push(1'b0, 18'h40, 18'h44);
    drain("drain_t6");

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
